// File: rtl/decoder_proj_pkg.sv
// Shared constants for the registered hex decoder: io_in field positions,
// output widths and the gfedcba seven-segment table.
package decoder_proj_pkg;

  localparam int IO_W     = 7;
  localparam int CODE_W   = 4;
  localparam int DEC_W    = 16;
  localparam int SEG_W    = 7;

  localparam int IDX_CODE_LSB = 0;
  localparam int IDX_CODE_MSB = 3;
  localparam int IDX_ENABLE   = 4;
  localparam int IDX_HOLD     = 5;
  localparam int IDX_INVERT   = 6;

  // Segment bit 0 is 'a', bit 6 is 'g'.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/decoder_proj_formal_hex_to_7seg.sv
// Combinational hex digit to seven-segment pattern lookup (gfedcba order).
module hex_to_7seg
  import decoder_proj_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg
);

  assign seg = SEG_TABLE[code];

endmodule

// File: rtl/decoder_proj_formal.sv
// Registered one-hot and seven-segment decoder with hold and output polarity.
// Define DECODER_PROJ_FORMAL_EN to compile in embedded assertions and covers.
module decoder_proj_formal
  import decoder_proj_pkg::*;
(
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [IO_W-1:0]  io_in,
  output logic [DEC_W-1:0] dec_out,
  output logic [SEG_W-1:0] seg_out,
  output logic             valid
);

  logic [CODE_W-1:0] code;
  logic              enable;
  logic              hold;
  logic              invert;
  logic [SEG_W-1:0]  seg_lut;

  // True-polarity decode is stored; the registered invert bit is applied at
  // the output so polarity and data always change on the same edge.
  logic [DEC_W-1:0]  dec_q;
  logic [SEG_W-1:0]  seg_q;
  logic              valid_q;
  logic              inv_q;

  assign code   = io_in[IDX_CODE_MSB:IDX_CODE_LSB];
  assign enable = io_in[IDX_ENABLE];
  assign hold   = io_in[IDX_HOLD];
  assign invert = io_in[IDX_INVERT];

  hex_to_7seg u_hex_to_7seg (
    .code (code),
    .seg  (seg_lut)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dec_q   <= '0;
      seg_q   <= '0;
      valid_q <= 1'b0;
      inv_q   <= 1'b0;
    end else if (!hold) begin
      inv_q <= invert;
      if (enable) begin
        dec_q   <= DEC_W'(1) << code;
        seg_q   <= seg_lut;
        valid_q <= 1'b1;
      end else begin
        dec_q   <= '0;
        seg_q   <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign dec_out = dec_q ^ {DEC_W{inv_q}};
  assign seg_out = seg_q ^ {SEG_W{inv_q}};
  assign valid   = valid_q;

`ifdef DECODER_PROJ_FORMAL_EN
  logic [CODE_W-1:0] code_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      code_q <= '0;
    end else if (!hold && enable) begin
      code_q <= code;
    end
  end

  a_one_hot_cold: assert property (@(posedge wb_clk_i)
    valid |-> $onehot(dec_out ^ {DEC_W{inv_q}}));

  a_seg_match: assert property (@(posedge wb_clk_i)
    valid |-> (seg_out == (SEG_TABLE[code_q] ^ {SEG_W{inv_q}})));

  a_reset_zero: assert property (@(posedge wb_clk_i)
    wb_rst_i |=> (dec_out == '0 && seg_out == '0 && !valid));

  for (genvar c = 0; c < 16; c++) begin : g_cov_code
    for (genvar p = 0; p < 2; p++) begin : g_cov_pol
      c_code_pol: cover property (@(posedge wb_clk_i)
        valid && code_q == CODE_W'(c) && inv_q == 1'(p));
    end
  end
`endif

endmodule

// File: tb/tb_decoder_proj_formal.sv
// Directed self-checking bench for decoder_proj_formal: reset, decode,
// polarity, hold priority, disabled update and a full code sweep.
module tb_decoder_proj_formal;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [6:0]  io_in    = 7'h00;
  logic [15:0] dec_out;
  logic [6:0]  seg_out;
  logic        valid;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_exp [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  decoder_proj_formal dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .io_in    (io_in),
    .dec_out  (dec_out),
    .seg_out  (seg_out),
    .valid    (valid)
  );

  // driver: apply inputs away from the edge, let one edge sample them
  task automatic step(input logic rst, input logic [6:0] v);
    wb_rst_i = rst;
    io_in    = v;
    @(posedge wb_clk_i);
    #1;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [15:0] d,
                     input logic [6:0] s, input logic v);
    checks++;
    assert (dec_out === d && seg_out === s && valid === v)
    else begin
      failures++;
      $error("FAIL %s: observed dec=%h seg=%h valid=%b expected dec=%h seg=%h valid=%b",
             tag, dec_out, seg_out, valid, d, s, v);
    end
  endtask

  initial begin
    #1;
    step(1'b1, 7'b0000000);
    chk("reset", 16'h0000, 7'h00, 1'b0);
    step(1'b1, 7'b1110101);
    chk("reset_over_hold", 16'h0000, 7'h00, 1'b0);

    step(1'b0, 7'b0010011);
    chk("code3", 16'h0008, 7'h4F, 1'b1);
    step(1'b0, 7'b1011111);
    chk("inv_codeF", 16'h7FFF, 7'h0E, 1'b1);

    step(1'b0, 7'b0010101);
    chk("code5", 16'h0020, 7'h6D, 1'b1);
    step(1'b0, 7'b1100001);
    chk("hold_en0", 16'h0020, 7'h6D, 1'b1);
    step(1'b0, 7'b1110000);
    chk("hold_wins_en", 16'h0020, 7'h6D, 1'b1);

    step(1'b0, 7'b0000001);
    chk("disabled", 16'h0000, 7'h00, 1'b0);
    step(1'b0, 7'b1000001);
    chk("disabled_inv", 16'hFFFF, 7'h7F, 1'b0);

    step(1'b0, 7'b1010000);
    chk("inv_code0", 16'hFFFE, 7'h40, 1'b1);
    step(1'b0, 7'b0100000);
    chk("hold_keeps_inv", 16'hFFFE, 7'h40, 1'b1);
    step(1'b0, 7'b0010000);
    chk("inv_release", 16'h0001, 7'h3F, 1'b1);

    step(1'b0, 7'b0010010);
    chk("code2", 16'h0004, 7'h5B, 1'b1);
    step(1'b1, 7'b0110010);
    chk("reset_hold_valid", 16'h0000, 7'h00, 1'b0);
    step(1'b0, 7'b0010111);
    chk("first_after_reset", 16'h0080, 7'h07, 1'b1);

    step(1'b0, 7'b1011010);
    chk("inv_codeA", 16'hFBFF, 7'h08, 1'b1);
    step(1'b1, 7'b1011010);
    chk("reset_discards", 16'h0000, 7'h00, 1'b0);

    for (int c = 0; c < 16; c++) begin
      step(1'b0, {3'b001, 4'(c)});
      chk($sformatf("sweep_%0d", c), 16'(1) << c, seg_exp[c], 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_proj_formal.md
DECODER_PROJ_FORMAL -- requirements
Module: decoder_proj_formal

Interface
- REQ-001: wb_clk_i  input  1  single clock; all state updates on its rising edge.
- REQ-002: wb_rst_i  input  1  reset, synchronous, active-high.
- REQ-003: io_in  input  7  control and data input; sampled on every rising clock edge.
  - [3:0] code
  - [4] enable
  - [5] hold
  - [6] invert
- REQ-004: dec_out  output  16  registered one-hot decode of code.
- REQ-005: seg_out  output  7  registered hex seven-segment pattern, bit order gfedcba (bit0 = a).
- REQ-006: valid  output  1  registered; 1 when outputs reflect an enabled decode.
- REQ-007: The block SHALL have no parameters; all widths are fixed as listed.

Function
- REQ-008: Latency SHALL be exactly one cycle: outputs after edge N reflect io_in sampled at edge N.
- REQ-009: Priority per edge SHALL be: reset, then hold, then the enable/disabled update.
- REQ-010: With hold=1 and reset low, dec_out, seg_out, valid and the internal invert register SHALL keep their values, regardless of the other bits.
- REQ-011: With hold=0 and enable=1, the update SHALL be:
  - dec_out = (1 << code) XOR {16{invert}}
  - seg_out = SEG(code) XOR {7{invert}}
  - valid = 1
- REQ-012: With hold=0 and enable=0, the update SHALL be:
  - dec_out = {16{invert}}
  - seg_out = {7{invert}}
  - valid = 0
- REQ-013: SEG table, code 0..F, SHALL be 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (hex).
- REQ-014: When invert=0 and valid=1, dec_out SHALL have exactly one bit set, at index code; when invert=1 it SHALL have exactly one bit clear.
- REQ-015: invert SHALL be registered alongside the outputs, so a polarity change takes effect on the same edge as the data.
- REQ-016: Code wrap-around: code=F SHALL drive dec_out bit 15; there is no code beyond F.
- REQ-017: Simultaneous hold=1 and enable=1 SHALL freeze the outputs (hold wins).

Reset
- REQ-018: wb_rst_i=1 at an edge SHALL set dec_out=0, seg_out=0, valid=0 and the invert register to 0, overriding hold.
- REQ-019: Reset asserted mid-operation SHALL discard the pending decode.
- REQ-020: The first edge with reset low SHALL perform a normal update per REQ-010 to REQ-012.

Configuration
- REQ-021: Macro DECODER_PROJ_FORMAL_EN SHALL compile in embedded properties:
  - assert one-hot / one-cold of dec_out whenever valid=1
  - assert seg_out equals SEG(code), with polarity applied, for the captured code
  - assert all outputs are zero in the cycle after reset
  - cover every code 0..F decoded with valid=1, under both polarities
- REQ-022: Without DECODER_PROJ_FORMAL_EN, no property, assertion or cover logic SHALL be present, and function SHALL be identical.

Structure
- REQ-023: Package decoder_proj_pkg SHALL hold the io_in field index constants, the 16-entry SEG table constant and the output width constants.
- REQ-024: One sub-module, hex_to_7seg (combinational, 4-bit in, 7-bit out, uses the package table), SHALL be instantiated; all registers SHALL reside in decoder_proj_formal.

Verification
- REQ-025: Reset then io_in=7'b0010011 (enable=1, code=3) -> next cycle dec_out=16'h0008, seg_out=7'h4F, valid=1.
- REQ-026: io_in=7'b1011111 (invert=1, enable=1, code=F) -> dec_out=16'h7FFF, seg_out=7'h0E, valid=1.
- REQ-027: Load code=5 enabled, then io_in=7'b1100001 (hold=1, enable=0) -> outputs remain dec_out=16'h0020, seg_out=7'h6D, valid=1.
- REQ-028: io_in=7'b0000001 (enable=0, hold=0) -> dec_out=0, seg_out=0, valid=0; with invert=1 -> dec_out=16'hFFFF, seg_out=7'h7F, valid=0.
- REQ-029: wb_rst_i=1 while hold=1 and valid=1 -> next cycle all outputs 0.
- REQ-030: Sweep code 0..F enabled, invert=0 -> dec_out=1<<code and seg_out matches REQ-013 every cycle, one cycle latency.
